// File: rtl/traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl
//   Two-road intersection controller. Each road gets a fixed green and yellow
//   phase, and the two roads are separated by all-red clearance intervals. A
//   latched pedestrian request inserts an all-red WALK phase at the next
//   clearance interval. A maintenance request overrides everything with
//   flashing yellow on both roads. All phase timing counts pulses of the
//   shared 1 Hz tick strobe, never raw clock cycles.
//
// Ports
//   clk       in   system clock, all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   tick      in   one-clock timing strobe; phase time advances only on it
//   ped_req   in   pedestrian button level, sampled every clock
//   flash     in   maintenance request level, sampled every clock
//   ns_g/y/r  out  north-south lamps
//   ew_g/y/r  out  east-west lamps
//   walk      out  pedestrian walk lamp
//   ped_wait  out  pedestrian request latched and not yet serviced
//   phase     out  current state code (NS_G=0 ... FLASH=7)
// ----------------------------------------------------------------------------
module traffic_light_ctrl #(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 3,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       flash,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_NS = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_EW = 3'd5,
        WALK  = 3'd6,
        FLASH = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);

    state_t           state;
    state_t           state_nxt;
    state_t           target;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ped_wait_nxt;
    logic             next_ns;
    logic             next_ns_nxt;
    logic             fl_bit;
    logic             fl_bit_nxt;

    // The counter is loaded with DUR-1 on entry so a state lasts DUR ticks:
    // the tick seen at cnt==0 is the last one and takes the transition.
    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        case (s)
            NS_G, EW_G:   load_for = GREEN_LD;
            NS_Y, EW_Y:   load_for = YELLOW_LD;
            AR_NS, AR_EW: load_for = ALLRED_LD;
            WALK:         load_for = WALK_LD;
            default:      load_for = '0;
        endcase
    endfunction

    // State, phase counter, pedestrian latch, road-after-walk flag and the
    // flash blink bit. Reset starts a fresh full NS green phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= NS_G;
            cnt      <= GREEN_LD;
            ped_wait <= 1'b0;
            next_ns  <= 1'b0;
            fl_bit   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ped_wait <= ped_wait_nxt;
            next_ns  <= next_ns_nxt;
            fl_bit   <= fl_bit_nxt;
        end
    end

    // Next-state logic. Priority is flash entry first, then leaving FLASH,
    // then tick-driven phase timing. A tick that coincides with the flash
    // assertion is simply swallowed because the flash branch wins.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ped_wait_nxt = ped_wait | ped_req;
        next_ns_nxt  = next_ns;
        fl_bit_nxt   = fl_bit;
        target       = state;

        // Button presses while the walk lamp is already lit are not remembered.
        if (state == WALK) begin
            ped_wait_nxt = ped_wait;
        end

        if (flash && (state != FLASH)) begin
            state_nxt  = FLASH;
            fl_bit_nxt = 1'b1;
        end else if (state == FLASH) begin
            if (!flash) begin
                // Leave maintenance through a clearance interval into NS green.
                state_nxt   = AR_EW;
                cnt_nxt     = ALLRED_LD;
                next_ns_nxt = 1'b1;
            end else if (tick) begin
                fl_bit_nxt = ~fl_bit;
            end
        end else if (tick) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - 1'b1;
            end else begin
                case (state)
                    NS_G:  target = NS_Y;
                    NS_Y:  target = AR_NS;
                    AR_NS: begin
                        target      = ped_wait ? WALK : EW_G;
                        next_ns_nxt = 1'b0;
                    end
                    EW_G:  target = EW_Y;
                    EW_Y:  target = AR_EW;
                    AR_EW: begin
                        target      = ped_wait ? WALK : NS_G;
                        next_ns_nxt = 1'b1;
                    end
                    WALK:  target = next_ns ? NS_G : EW_G;
                    default: target = NS_G;
                endcase
                state_nxt = target;
                cnt_nxt   = load_for(target);
                // Entering WALK services the request, overriding a new press.
                if (target == WALK) begin
                    ped_wait_nxt = 1'b0;
                end
            end
        end
    end

    // Moore lamp decode. Every non-flash state lights exactly one lamp per
    // road; FLASH blinks both yellows together.
    always_comb begin
        ns_g = 1'b0;
        ns_y = 1'b0;
        ns_r = 1'b0;
        ew_g = 1'b0;
        ew_y = 1'b0;
        ew_r = 1'b0;
        walk = 1'b0;
        case (state)
            NS_G:  begin ns_g = 1'b1; ew_r = 1'b1; end
            NS_Y:  begin ns_y = 1'b1; ew_r = 1'b1; end
            EW_G:  begin ns_r = 1'b1; ew_g = 1'b1; end
            EW_Y:  begin ns_r = 1'b1; ew_y = 1'b1; end
            AR_NS, AR_EW: begin ns_r = 1'b1; ew_r = 1'b1; end
            WALK:  begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
            FLASH: begin ns_y = fl_bit; ew_y = fl_bit; end
            default: begin ns_r = 1'b1; ew_r = 1'b1; end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//   Directed bench for traffic_light_ctrl with default parameters. Expected
//   phase codes, lamp patterns and pedestrian latch values are written out by
//   hand for each step.
// ----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       ped_req;
    logic       flash;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_wait;
    logic [2:0] phase;

    int compared   = 0;
    int mismatched = 0;

    // Lamp patterns packed as {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
    localparam logic [6:0] L_NSG   = 7'b1000010;
    localparam logic [6:0] L_NSY   = 7'b0100010;
    localparam logic [6:0] L_AR    = 7'b0010010;
    localparam logic [6:0] L_EWG   = 7'b0011000;
    localparam logic [6:0] L_EWY   = 7'b0010100;
    localparam logic [6:0] L_WALK  = 7'b0010011;
    localparam logic [6:0] L_FLON  = 7'b0100100;
    localparam logic [6:0] L_FLOFF = 7'b0000000;

    // One full cycle with a tick on every clock, starting from reset.
    logic [2:0] t6_ph [17] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                               3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
    logic [6:0] t6_lp [17] = '{L_NSG, L_NSG, L_NSG, L_NSG, L_NSG, L_NSY, L_NSY, L_AR,
                               L_EWG, L_EWG, L_EWG, L_EWG, L_EWG, L_EWY, L_EWY, L_AR, L_NSG};

    traffic_light_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .ped_req  (ped_req),
        .flash    (flash),
        .ns_g     (ns_g),
        .ns_y     (ns_y),
        .ns_r     (ns_r),
        .ew_g     (ew_g),
        .ew_y     (ew_y),
        .ew_r     (ew_r),
        .walk     (walk),
        .ped_wait (ped_wait),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the input levels for n clock edges, returning 1 time unit after
    // the last rising edge so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic t, input logic p, input logic f, input int n);
        for (int i = 0; i < n; i++) begin
            tick    = t;
            ped_req = p;
            flash   = f;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] ph,
                               input logic [6:0] lamps, input logic pw);
        logic [6:0] obs_lamps;
        obs_lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};
        compared++;
        assert ({phase, obs_lamps, ped_wait} === {ph, lamps, pw}) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed phase=%0d lamps=%b ped_wait=%b, expected phase=%0d lamps=%b ped_wait=%b",
                   tag, phase, obs_lamps, ped_wait, ph, lamps, pw);
        end
    endtask

    // Stay in one state for n ticks, checking it before every tick.
    task automatic walkState(input string tag, input logic [2:0] ph, input logic [6:0] lamps,
                             input logic pw, input int n, input logic preq);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_t%0d", tag, i), ph, lamps, pw);
            applyStimulus(1'b1, preq, 1'b0, 1);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        tick    = 1'b0;
        ped_req = 1'b0;
        flash   = 1'b0;

        // Reset state and holding without ticks
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkOutput("reset", 3'd0, L_NSG, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("hold_no_tick", 3'd0, L_NSG, 1'b0);

        // Test 1: plain cycle, 16 ticks per period
        walkState("t1_nsg",  3'd0, L_NSG, 1'b0, 5, 1'b0);
        walkState("t1_nsy",  3'd1, L_NSY, 1'b0, 2, 1'b0);
        walkState("t1_arns", 3'd2, L_AR,  1'b0, 1, 1'b0);
        walkState("t1_ewg",  3'd3, L_EWG, 1'b0, 5, 1'b0);
        walkState("t1_ewy",  3'd4, L_EWY, 1'b0, 2, 1'b0);
        walkState("t1_arew", 3'd5, L_AR,  1'b0, 1, 1'b0);
        checkOutput("t1_wrap", 3'd0, L_NSG, 1'b0);

        // Test 2: one-clock press on NS green tick 2 inserts WALK before EW
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("t2_latch", 3'd0, L_NSG, 1'b1);
        walkState("t2_nsg",  3'd0, L_NSG,  1'b1, 3, 1'b0);
        walkState("t2_nsy",  3'd1, L_NSY,  1'b1, 2, 1'b0);
        walkState("t2_arns", 3'd2, L_AR,   1'b1, 1, 1'b0);
        walkState("t2_walk", 3'd6, L_WALK, 1'b0, 3, 1'b0);
        walkState("t2_ewg",  3'd3, L_EWG,  1'b0, 5, 1'b0);
        walkState("t2_ewy",  3'd4, L_EWY,  1'b0, 2, 1'b0);
        walkState("t2_arew", 3'd5, L_AR,   1'b0, 1, 1'b0);
        checkOutput("t2_back", 3'd0, L_NSG, 1'b0);

        // Test 3: button held during WALK is ignored, re-latches after exit
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("t3_latch", 3'd0, L_NSG, 1'b1);
        walkState("t3_nsg",  3'd0, L_NSG,  1'b1, 5, 1'b0);
        walkState("t3_nsy",  3'd1, L_NSY,  1'b1, 2, 1'b0);
        walkState("t3_arns", 3'd2, L_AR,   1'b1, 1, 1'b0);
        walkState("t3_walk", 3'd6, L_WALK, 1'b0, 3, 1'b1);
        checkOutput("t3_exit", 3'd3, L_EWG, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("t3_relatch", 3'd3, L_EWG, 1'b1);
        walkState("t3_ewg",   3'd3, L_EWG,  1'b1, 5, 1'b0);
        walkState("t3_ewy",   3'd4, L_EWY,  1'b1, 2, 1'b0);
        walkState("t3_arew",  3'd5, L_AR,   1'b1, 1, 1'b0);
        walkState("t3_walk2", 3'd6, L_WALK, 1'b0, 3, 1'b0);
        checkOutput("t3_back", 3'd0, L_NSG, 1'b0);

        // Test 4: flash mid EW green, blink over four ticks, then recover
        walkState("t4_nsg",  3'd0, L_NSG, 1'b0, 5, 1'b0);
        walkState("t4_nsy",  3'd1, L_NSY, 1'b0, 2, 1'b0);
        walkState("t4_arns", 3'd2, L_AR,  1'b0, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("t4_ewg", 3'd3, L_EWG, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput("t4_fl_entry", 3'd7, L_FLON, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2);
        checkOutput("t4_fl_hold", 3'd7, L_FLON, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput("t4_fl_tick1", 3'd7, L_FLOFF, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput("t4_fl_tick2", 3'd7, L_FLON, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput("t4_fl_tick3", 3'd7, L_FLOFF, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput("t4_fl_tick4", 3'd7, L_FLON, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("t4_arew", 3'd5, L_AR, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkOutput("t4_arew_hold", 3'd5, L_AR, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("t4_nsg", 3'd0, L_NSG, 1'b0);

        // Test 4b: request made during FLASH is served after it
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("t4b_fl", 3'd7, L_FLON, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("t4b_fl_ped", 3'd7, L_FLON, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("t4b_arew", 3'd5, L_AR, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        walkState("t4b_walk", 3'd6, L_WALK, 1'b0, 3, 1'b0);
        checkOutput("t4b_nsg", 3'd0, L_NSG, 1'b0);

        // Test 5: asynchronous reset mid EW yellow, then long idle
        walkState("t5_nsg",  3'd0, L_NSG, 1'b0, 5, 1'b0);
        walkState("t5_nsy",  3'd1, L_NSY, 1'b0, 2, 1'b0);
        walkState("t5_arns", 3'd2, L_AR,  1'b0, 1, 1'b0);
        walkState("t5_ewg",  3'd3, L_EWG, 1'b0, 5, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("t5_ewy", 3'd4, L_EWY, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async", 3'd0, L_NSG, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3);
        checkOutput("t5_in_reset", 3'd0, L_NSG, 1'b0);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1000);
        checkOutput("t5_idle", 3'd0, L_NSG, 1'b0);
        walkState("t5_full", 3'd0, L_NSG, 1'b0, 5, 1'b0);
        checkOutput("t5_nsy", 3'd1, L_NSY, 1'b0);

        // Test 6: tick on every clock, durations become clock counts
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            checkOutput($sformatf("t6_clk%0d", i), t6_ph[i], t6_lp[i], 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
